serial_bit_feeder: RTL and testbench

Upstream stage for the serial sequence detector. It accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out one bit per clock as `dout`/`dout_valid`. `dout` drives the detector's `din` directly. Consecutive words are streamed without bubbles unless an inter-word gap is configured.

---
 rtl/serial_bit_feeder.sv | 130 +++++++++++++
 tb/tb_serial_bit_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector: one-word hold buffer,
// a shift register streaming one bit per clock, and an optional inter-word gap.
module serial_bit_feeder #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             load;
    logic             gap_start;
    logic             accept;
    logic             cur_bit;

    // Handshake: a word transfers on an edge where in_valid && in_ready;
    // in_ready depends only on hold_full and rst, never on in_valid.
    assign in_ready = !hold_full && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        gap_start = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    if (HAS_GAP) begin
                        gap_start = 1'b1;
                        state_nx  = GAP;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    if (hold_full) begin
                        load     = 1'b1;
                        state_nx = SHIFT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= 4'd0;
        end else begin
            state <= state_nx;

            // accept and load are exclusive: load needs hold_full, accept needs it clear
            if (accept) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                shreg   <= hold_data;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                if (MSB_FIRST != 0) begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end else begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                end
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (gap_start) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    assign cur_bit     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign dout_valid  = (state == SHIFT);
    assign dout        = dout_valid && cur_bit;
    assign frame_start = dout_valid && (bit_cnt == '0);
    assign busy        = (state != IDLE) || hold_full;
    assign fsm_state   = state;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: three 4-bit instances (MSB/no gap,
// MSB/gap 2, LSB/no gap), each observation packed as {in_ready,busy,dout_valid,dout,frame_start}.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_valid = 3'b000;
  logic [3:0] in_data [3];
  logic [2:0] in_ready, dout, dout_valid, frame_start, busy;
  logic [1:0] fsm_state [3];

  logic [4:0] exp_q[$];
  logic [3:0] drv_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         last_wait = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
    .frame_start(frame_start[0]), .busy(busy[0]), .fsm_state(fsm_state[0]));

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(2)) dut_gap (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
    .frame_start(frame_start[1]), .busy(busy[1]), .fsm_state(fsm_state[1]));

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
    .frame_start(frame_start[2]), .busy(busy[2]), .fsm_state(fsm_state[2]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] sample(input int w);
    return {in_ready[w], busy[w], dout_valid[w], dout[w], frame_start[w]};
  endfunction

  // Presents every word in drv_q to instance w, holding in_valid until each is taken.
  task automatic drive(input int w);
    int waits;
    in_valid[w] = 1'b1;
    while (drv_q.size() > 0) begin
      in_data[w] = drv_q[0];
      waits = 0;
      while (!in_ready[w] && waits < 50) begin
        tick();
        waits++;
      end
      if (waits >= 50) begin
        check("drv_timeout", 32'd1, 32'd0);
        drv_q.delete();
      end else begin
        tick();
        void'(drv_q.pop_front());
        last_wait = waits;
      end
    end
    in_valid[w] = 1'b0;
  endtask

  task automatic observe(input string name, input int w, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) check($sformatf("%s_noexp%0d", name, i), 32'd1, 32'd0);
      else check($sformatf("%s[%0d]", name, i), 32'(sample(w)), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic push_single_1101();
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11110);
    exp_q.push_back(5'b11100);
    exp_q.push_back(5'b11110);
    exp_q.push_back(5'b10000);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) in_data[i] = 4'h0;

    // reset
    tick();
    tick();
    for (int w = 0; w < 3; w++) check($sformatf("reset%0d", w), 32'(sample(w)), 32'h00);
    rst = 1'b0;
    tick();
    for (int w = 0; w < 3; w++) check($sformatf("post_reset%0d", w), 32'(sample(w)), 32'h10);

    // single word 1101, MSB first
    drv_q = '{4'hD};
    push_single_1101();
    fork
      drive(0);
      observe("single", 0, 6);
    join

    // back-to-back D then 6
    drv_q = '{4'hD, 4'h6};
    exp_q = '{5'b01000, 5'b11111, 5'b01110, 5'b01100, 5'b01110,
              5'b11101, 5'b11110, 5'b11110, 5'b11100, 5'b10000};
    fork
      drive(0);
      observe("b2b", 0, 10);
    join

    // backpressure: 9, 3, E; the third waits until 3 is loaded
    drv_q = '{4'h9, 4'h3, 4'hE};
    exp_q = '{5'b01000, 5'b11111, 5'b01100, 5'b01100, 5'b01110,
              5'b11101, 5'b01100, 5'b01110, 5'b01110,
              5'b11111, 5'b11110, 5'b11110, 5'b11100, 5'b10000};
    fork
      drive(0);
      observe("bp", 0, 14);
    join
    check("bp_third_wait", 32'(last_wait), 32'd3);

    // reset after two bits of D
    drv_q = '{4'hD};
    exp_q = '{5'b01000, 5'b11111, 5'b11110};
    fork
      drive(0);
      observe("rst_pre", 0, 3);
    join
    rst = 1'b1;
    tick();
    check("rst_mid", 32'(sample(0)), 32'h00);
    rst = 1'b0;
    exp_q = '{5'b10000, 5'b10000};
    observe("rst_after", 0, 2);
    drv_q = '{4'hD};
    push_single_1101();
    fork
      drive(0);
      observe("rst_fresh", 0, 6);
    join

    // gap of 2 between two D words
    drv_q = '{4'hD, 4'hD};
    exp_q = '{5'b01000, 5'b11111, 5'b01110, 5'b01100, 5'b01110,
              5'b01000, 5'b01000,
              5'b11111, 5'b11110, 5'b11100, 5'b11110,
              5'b11000, 5'b11000, 5'b10000};
    fork
      drive(1);
      observe("gap", 1, 14);
    join

    // LSB first: 1011 -> 1,1,0,1
    drv_q = '{4'b1011};
    push_single_1101();
    fork
      drive(2);
      observe("lsb", 2, 6);
    join

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
